cordic_arctan_sched: RTL
========================

// Module: cordic_arctan_sched
// PURPOSE
//  Shares one pipelined cordic_arctan core between N_REQ requesters (e.g. phase detectors, angle trackers).
//  Round-robin arbitrates (y,x) requests, issues one per cycle, tracks requester IDs in-order and routes theta back.
//  Watchdog flushes lost operations. Sits between requesters and the core; core ports are brought out, not instanced.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  MAX_INFLIGHT 16   ops outstanding in core (tag FIFO depth, power of 2)
//  TIMEOUT      64   cycles with ops outstanding and no core result before flush
//  W            16   sample/angle width, signed Q2.13 (0x2000 = 1.0, pi/4 = 0x1921)
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous active-low reset
//  req_valid_i    in   N_REQ    per-requester request valid
//  req_ready_o    out  N_REQ    per-requester accept (one-hot or zero)
//  req_y_i        in   N_REQ*W  packed y operands, requester k at [k*W +: W]
//  req_x_i        in   N_REQ*W  packed x operands
//  core_valid_o   out  1        to cordic valid_in
//  core_y_o       out  W        to cordic y_in
//  core_x_o       out  W        to cordic x_in
//  core_valid_i   in   1        from cordic valid_out
//  core_theta_i   in   W        from cordic theta_out
//  res_valid_o    out  1        result strobe, one cycle
//  res_id_o       out  $clog2(N_REQ)  requester owning result
//  res_theta_o    out  W        signed Q2.13 angle, radians
//  inflight_o     out  $clog2(MAX_INFLIGHT)+1  ops outstanding
//  err_timeout_o  out  1        sticky: watchdog flush occurred
//  err_orphan_o   out  1        sticky: core result arrived with empty tag FIFO
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, RR pointer 0, FIFO empty, watchdog 0, sticky errors cleared.
//  Grant: when inflight_o < MAX_INFLIGHT, req_ready_o = one-hot of first valid requester at/after RR pointer;
//   combinational from req_valid_i; ready never asserted for a non-valid requester. Handshake = valid&ready.
//  On handshake of k: register y/x into core_*_o, core_valid_o=1 next cycle (exactly 1 cycle pulse per op);
//   push k into tag FIFO; RR pointer <= k+1 mod N_REQ. No handshake -> core_valid_o=0, pointer holds.
//  Requesters keep y/x stable only in the handshake cycle; operands are captured then.
//  Result: on core_valid_i with FIFO non-empty, pop head; next cycle res_valid_o=1, res_id_o=head,
//   res_theta_o=core_theta_i (1-cycle registered). Results return strictly in issue order (core is in-order).
//  core_valid_i with FIFO empty: dropped, no res_valid_o, err_orphan_o<=1.
//  Push and pop same cycle: both occur, inflight unchanged; allowed even when full (pop frees a slot next cycle only,
//   ready computed from registered count).
//  inflight_o = FIFO occupancy; increments on handshake, decrements on pop.
//  Watchdog: counts cycles with inflight_o>0 and no core_valid_i; reset to 0 on any core_valid_i or inflight_o==0.
//   On reaching TIMEOUT: FIFO cleared, inflight_o<=0, err_timeout_o<=1, no res_valid_o for lost ops;
//   that cycle req_ready_o forced 0. Later stray core results flag err_orphan_o.
//  Reset mid-operation: all state discarded immediately; pending results lost; core reset is the top's responsibility.
//  Arithmetic: no operand modification; theta passed through unchanged (full range -pi..pi in Q2.13).
// STRUCTURE
//  cordic_sched_pkg: typedef logic signed [15:0] q2_13_t; localparams Q_ONE=16'h2000, Q_PI_4=16'h1921;
//   typedef struct {q2_13_t y, x;} atan_req_t.
//  Sub-module cordic_tag_fifo: sync FIFO of IDs, async active-low reset, flush input, simultaneous push/pop, count out.
//  Top: RR arbiter (rotate-priority-encode), issue register, result register, watchdog counter, sticky flags.
// TESTING (bench instances real cordic_arctan, sync rst driven = !rst_n)
//  Req0 y=x=0x2000 alone -> one core_valid_o pulse, later res_valid_o with id 0, theta 0x1921.
//  Req1 y=0x2000 x=0x4000 and req2 y=0xE000 x=0x2000 same cycle, pointer 0 -> req1 issued first;
//   results id1 theta 3798+-8 then id2 theta 0xE6DD+-8, back-to-back issue order preserved.
//  All 4 requesters valid continuously 40 cycles -> grants 0,1,2,3,0,... no requester starved; ids match results.
//  Model core with valid_out stalled, MAX_INFLIGHT=16 -> exactly 16 handshakes then req_ready_o=0, inflight_o=16;
//   release -> 16 results in order, ready returns.
//  Stall core TIMEOUT cycles with 3 inflight -> err_timeout_o=1, inflight_o=0; late core_valid_i -> err_orphan_o=1.
//  rst_n pulsed low with 5 inflight -> outputs 0 asynchronously; after release, new req0 (-0x2000,-0x4000)... wait
//   y=-0x4000 x=-0x2000 -> theta -16666+-8, id 0.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the cordic_arctan request scheduler.
package cordic_sched_pkg;

  typedef logic signed [15:0] q2_13_t;

  localparam q2_13_t Q_ONE  = 16'sh2000;
  localparam q2_13_t Q_PI_4 = 16'sh1921;

  typedef struct packed {
    q2_13_t y;
    q2_13_t x;
  } atan_req_t;

  // Single-step modulo for values known to be below 2*n.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order FIFO of requester IDs for ops outstanding in the core; flush drops everything.
module cordic_tag_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [IDW-1:0]         i_push_id,
  input  logic                   i_pop,
  output logic [IDW-1:0]         o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [IDW-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/cordic_arctan_sched.sv
// Round-robin scheduler sharing one in-order cordic_arctan core among N_REQ requesters,
// with in-order ID tagging of results and a watchdog that flushes lost operations.
module cordic_arctan_sched
  import cordic_sched_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned W            = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ*W-1:0]              req_y_i,
  input  logic [N_REQ*W-1:0]              req_x_i,
  output logic                            core_valid_o,
  output logic [W-1:0]                    core_y_o,
  output logic [W-1:0]                    core_x_o,
  input  logic                            core_valid_i,
  input  logic [W-1:0]                    core_theta_i,
  output logic                            res_valid_o,
  output logic [$clog2(N_REQ)-1:0]        res_id_o,
  output logic [W-1:0]                    res_theta_o,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
  output logic                            err_timeout_o,
  output logic                            err_orphan_o
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  logic [IDW-1:0] r_ptr;
  logic           r_core_valid;
  logic [W-1:0]   r_core_y;
  logic [W-1:0]   r_core_x;
  logic           r_res_valid;
  logic [IDW-1:0] r_res_id;
  logic [W-1:0]   r_res_theta;
  logic [WDW-1:0] r_wdog;
  logic           r_err_timeout;
  logic           r_err_orphan;

  logic           w_found;
  logic [IDW-1:0] w_gnt_id;
  logic [W-1:0]   w_sel_y;
  logic [W-1:0]   w_sel_x;
  logic           w_allow;
  logic           w_hs;
  logic           w_pop;
  logic           w_empty;
  logic           w_wd_fire;
  logic [IDW-1:0] w_head;
  logic [CW-1:0]  w_count;

  assign w_empty   = (w_count == '0);
  assign w_pop     = core_valid_i && !w_empty;
  // Fires on the TIMEOUT-th consecutive cycle with work outstanding and no core result.
  assign w_wd_fire = !w_empty && !core_valid_i && (r_wdog == WDW'(TIMEOUT - 1));
  assign w_allow   = (w_count < CW'(MAX_INFLIGHT)) && !w_wd_fire;
  assign w_hs      = w_allow && w_found;

  // Rotate-priority encode: first valid requester at or after the RR pointer.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_found     = 1'b0;
    w_gnt_id    = '0;
    w_sel_y     = '0;
    w_sel_x     = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = rr_wrap(32'(r_ptr) + i, N_REQ);
      if (!w_found && req_valid_i[IDW'(idx)]) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(idx);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == w_gnt_id) begin
        w_sel_y = req_y_i[k*W +: W];
        w_sel_x = req_x_i[k*W +: W];
      end
    end
    if (w_hs) req_ready_o[w_gnt_id] = 1'b1;
  end

  cordic_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .IDW   (IDW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (w_wd_fire),
    .i_push    (w_hs),
    .i_push_id (w_gnt_id),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_core_valid  <= 1'b0;
      r_core_y      <= '0;
      r_core_x      <= '0;
      r_res_valid   <= 1'b0;
      r_res_id      <= '0;
      r_res_theta   <= '0;
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
      r_err_orphan  <= 1'b0;
    end else begin
      r_core_valid <= w_hs;
      if (w_hs) begin
        r_core_y <= w_sel_y;
        r_core_x <= w_sel_x;
        r_ptr    <= IDW'(rr_wrap(32'(w_gnt_id) + 32'd1, N_REQ));
      end
      r_res_valid <= w_pop;
      if (w_pop) begin
        r_res_id    <= w_head;
        r_res_theta <= core_theta_i;
      end
      if (core_valid_i && w_empty) r_err_orphan <= 1'b1;
      if (w_wd_fire) r_err_timeout <= 1'b1;
      if (core_valid_i || w_empty || w_wd_fire) r_wdog <= '0;
      else                                      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign core_valid_o  = r_core_valid;
  assign core_y_o      = r_core_y;
  assign core_x_o      = r_core_x;
  assign res_valid_o   = r_res_valid;
  assign res_id_o      = r_res_id;
  assign res_theta_o   = r_res_theta;
  assign inflight_o    = w_count;
  assign err_timeout_o = r_err_timeout;
  assign err_orphan_o  = r_err_orphan;

endmodule
